mem_resp_ctrl: RTL and testbench

Memory-side responder for the pipelined 16-bit CPU. It accepts instruction-fetch requests from IF and load/store requests from MEM, arbitrates them onto one single-port multi-cycle main memory, and holds the requesting stage stalled until its word returns. Data requests win over fetches. A wait counter bounds every memory access.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/mem_wait_cnt.sv | 43 ++++
 rtl/mem_resp_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_resp_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Types and defaults shared by the memory responder and the pipeline's
// hazard/stall logic.
package cpu_mem_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 16;
    localparam int MAX_WAIT_DEF = 15;
    localparam int CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_WAIT = 3'd1,
        ST_D_RESP = 3'd2,
        ST_I_WAIT = 3'd3,
        ST_I_RESP = 3'd4
    } mem_state_e;

endpackage

// File: rtl/mem_wait_cnt.sv
// Wait-cycle counter bounding one memory access; term flags MAX_WAIT cycles
// elapsed since the last clear.
module mem_wait_cnt
    import cpu_mem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating next-count so a stuck access cannot wrap past the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TERM_VAL)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mem_resp_ctrl.sv
// Arbitrates CPU fetch and load/store requests onto one multi-cycle memory;
// data wins, and each port is stalled until its word comes back.
module mem_resp_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              err
);

    mem_state_e        state_q, state_d;
    logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_data_q, if_data_d, d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d;
    logic              cur_wr_q, cur_wr_d;
    logic              d_req_s, launch_d_s, launch_i_s, cnt_en_s, term_s;

    assign d_req_s = d_rd | d_wr;

    mem_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch_d_s | launch_i_s),
        .en   (cnt_en_s),
        .term (term_s)
    );

    // Arbitration, next state, and completion/hold-register updates.
    always_comb begin
        state_d    = state_q;
        launch_d_s = 1'b0;
        launch_i_s = 1'b0;
        cnt_en_s   = 1'b0;
        d_ack_d    = 1'b0;
        if_ack_d   = 1'b0;
        err_d      = 1'b0;
        d_rdata_d  = d_rdata_q;
        if_data_d  = if_data_q;
        case (state_q)
            ST_IDLE: begin
                if (d_req_s) begin
                    launch_d_s = 1'b1;
                end else if (if_req) begin
                    launch_i_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_D_WAIT: begin
                cnt_en_s = 1'b1;
                if (mem_valid) begin
                    // A store completion leaves the load data untouched.
                    d_rdata_d = cur_wr_q ? d_rdata_q : mem_rdata;
                    d_ack_d   = 1'b1;
                    state_d   = ST_D_RESP;
                end else if (term_s) begin
                    d_rdata_d = cur_wr_q ? d_rdata_q : '0;
                    d_ack_d   = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_D_RESP;
                end else begin
                    state_d = ST_D_WAIT;
                end
            end
            ST_I_WAIT: begin
                cnt_en_s = 1'b1;
                if (mem_valid) begin
                    if_data_d = mem_rdata;
                    if_ack_d  = 1'b1;
                    state_d   = ST_I_RESP;
                end else if (term_s) begin
                    if_data_d = '0;
                    if_ack_d  = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_I_RESP;
                end else begin
                    state_d = ST_I_WAIT;
                end
            end
            ST_D_RESP: begin
                // The port just served may not relaunch while the other waits.
                if (if_req) begin
                    launch_i_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_RESP: begin
                if (d_req_s) begin
                    launch_d_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (launch_d_s) begin
            state_d = ST_D_WAIT;
        end else if (launch_i_s) begin
            state_d = ST_I_WAIT;
        end else begin
            state_d = state_d;
        end
    end

    // Launch registers feeding the memory strobe, address and write data.
    always_comb begin
        mem_en_d    = launch_d_s | launch_i_s;
        mem_wr_d    = launch_d_s & d_wr;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cur_wr_d    = cur_wr_q;
        if (launch_d_s) begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            cur_wr_d    = d_wr;
        end else if (launch_i_s) begin
            mem_addr_d = if_addr;
            cur_wr_d   = 1'b0;
        end else begin
            cur_wr_d = cur_wr_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            cur_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            cur_wr_q    <= cur_wr_d;
        end
    end

    assign d_stall   = d_req_s & (state_q != ST_D_RESP);
    assign if_stall  = if_req & (state_q != ST_I_RESP);
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_data   = if_data_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench for mem_resp_ctrl: a latency-programmable memory model plus
// per-port scoreboards of expected completion data, error flag and cycle.
module tb_mem_resp_ctrl;

    logic        clk, rst;
    logic        if_req, d_rd, d_wr, mem_valid;
    logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] if_data, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, if_stall, d_ack, d_stall, mem_en, mem_wr, err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 3;
    bit mem_on = 1'b1;

    logic [15:0] exp_if_data[$];
    int          exp_if_cyc[$];
    logic [15:0] exp_d_data[$];
    logic        exp_d_err[$];
    int          exp_d_cyc[$];

    mem_resp_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack), .if_stall(if_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0010: mem_word = 16'hA1B2;
            16'h0012: mem_word = 16'h5678;
            16'h0200: mem_word = 16'h1234;
            default:  mem_word = a ^ 16'h5A5A;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: mem_valid for one cycle, lat cycles after mem_en.
    initial begin
        int cnt;
        logic [15:0] a_l;
        cnt = 0;
        a_l = 16'h0000;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_word(a_l);
                end
            end
            if (mem_en && mem_on) begin
                cnt = lat;
                a_l = mem_addr;
            end
        end
    end

    // Completion monitor: pops the scoreboards on every ack.
    initial begin
        forever begin
            @(negedge clk);
            if (if_ack) begin
                if (exp_if_data.size() == 0) begin
                    chk("if_ack_unexpected", 32'(if_ack), 32'd0);
                end else begin
                    chk("if_data", 32'(if_data), 32'(exp_if_data.pop_front()));
                    chk("if_ack_cycle", 32'(cyc), 32'(exp_if_cyc.pop_front()));
                end
            end
            if (d_ack) begin
                if (exp_d_data.size() == 0) begin
                    chk("d_ack_unexpected", 32'(d_ack), 32'd0);
                end else begin
                    chk("d_rdata", 32'(d_rdata), 32'(exp_d_data.pop_front()));
                    chk("d_err", 32'(err), 32'(exp_d_err.pop_front()));
                    chk("d_ack_cycle", 32'(cyc), 32'(exp_d_cyc.pop_front()));
                end
            end
            if (err && !d_ack && !if_ack) begin
                chk("err_without_ack", 32'(err), 32'd0);
            end
        end
    end

    initial begin
        int t0;
        rst = 1'b1; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        if_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_acks", 32'({if_ack, d_ack, err}), 32'd0);
        chk("rst_stalls", 32'({if_stall, d_stall, mem_wr}), 32'd0);
        chk("rst_regs", 32'(mem_addr | mem_wdata | if_data | d_rdata), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // Fetch only, L=3.
        lat = 3; t0 = cyc;
        if_req = 1'b1; if_addr = 16'h0010;
        exp_if_data.push_back(16'hA1B2); exp_if_cyc.push_back(t0 + 5);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_if_stall", 32'(if_stall), 32'(k <= 4));
            chk("t1_mem_en", 32'(mem_en), 32'(k == 1));
            chk("t1_if_ack", 32'(if_ack), 32'(k == 5));
            if (k == 1) chk("t1_mem_addr", 32'({mem_wr, mem_addr}), 32'h0010);
            @(posedge clk); #1;
            if (k == 4) if_req = 1'b0;
        end

        // Simultaneous load and fetch, L=2: data first, fetch with no bubble.
        lat = 2; t0 = cyc;
        d_rd = 1'b1; d_addr = 16'h0200; if_req = 1'b1; if_addr = 16'h0012;
        exp_d_data.push_back(16'h1234); exp_d_err.push_back(1'b0); exp_d_cyc.push_back(t0 + 4);
        exp_if_data.push_back(16'h5678); exp_if_cyc.push_back(t0 + 8);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("t2_mem_en", 32'(mem_en), 32'(k == 1 || k == 5));
            chk("t2_d_stall", 32'(d_stall), 32'(k <= 3));
            chk("t2_if_stall", 32'(if_stall), 32'(k <= 7));
            if (k == 1) chk("t2_mem_addr_d", 32'(mem_addr), 32'h0200);
            if (k == 5) chk("t2_mem_addr_i", 32'({mem_wr, mem_addr}), 32'h0012);
            @(posedge clk); #1;
            if (k == 4) d_rd = 1'b0;
            if (k == 7) if_req = 1'b0;
        end

        // Store, L=2: d_rdata keeps the previous load value.
        t0 = cyc;
        d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hBEEF;
        exp_d_data.push_back(16'h1234); exp_d_err.push_back(1'b0); exp_d_cyc.push_back(t0 + 4);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            chk("t3_mem_en", 32'(mem_en), 32'(k == 1));
            if (k == 1) begin
                chk("t3_mem_wr", 32'(mem_wr), 32'd1);
                chk("t3_mem_addr", 32'(mem_addr), 32'h0300);
                chk("t3_mem_wdata", 32'(mem_wdata), 32'hBEEF);
            end
            @(posedge clk); #1;
            if (k == 4) d_wr = 1'b0;
        end

        // Timeout: memory never answers.
        mem_on = 1'b0; t0 = cyc;
        d_rd = 1'b1; d_addr = 16'h0400;
        exp_d_data.push_back(16'h0000); exp_d_err.push_back(1'b1); exp_d_cyc.push_back(t0 + 17);
        for (int k = 0; k <= 19; k++) begin
            @(negedge clk);
            chk("t4_err", 32'(err), 32'(k == 17));
            chk("t4_d_stall", 32'(d_stall), 32'(k <= 16));
            chk("t4_mem_en", 32'(mem_en), 32'(k == 1));
            @(posedge clk); #1;
            if (k == 16) d_rd = 1'b0;
        end
        mem_on = 1'b1;

        // Reset during D_WAIT, stray mem_valid afterwards.
        lat = 4;
        d_rd = 1'b1; d_addr = 16'h0500;
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b1; d_rd = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            chk("t5_flags", 32'({mem_en, mem_wr, if_ack, d_ack, err, if_stall, d_stall}), 32'd0);
            chk("t5_regs", 32'(mem_addr | mem_wdata | if_data | d_rdata), 32'd0);
            @(posedge clk); #1;
        end

        // Fetch flushed mid-access, then a load served next.
        lat = 3; t0 = cyc;
        if_req = 1'b1; if_addr = 16'h0014;
        exp_if_data.push_back(mem_word(16'h0014)); exp_if_cyc.push_back(t0 + 5);
        exp_d_data.push_back(mem_word(16'h0600)); exp_d_err.push_back(1'b0); exp_d_cyc.push_back(t0 + 10);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("t6_if_stall", 32'(if_stall), 32'(k <= 1));
            chk("t6_d_stall", 32'(d_stall), 32'(k >= 3 && k <= 9));
            chk("t6_mem_en", 32'(mem_en), 32'(k == 1 || k == 6));
            if (k == 6) chk("t6_mem_addr", 32'({mem_wr, mem_addr}), 32'h0600);
            @(posedge clk); #1;
            if (k == 1) if_req = 1'b0;
            if (k == 2) begin d_rd = 1'b1; d_addr = 16'h0600; end
            if (k == 9) d_rd = 1'b0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("if_sb_drained", 32'(exp_if_data.size()), 32'd0);
        chk("d_sb_drained", 32'(exp_d_data.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
